// File: rtl/mult_pkg.sv
// Shared state encoding and helpers for the iterative multiply/divide controllers.
package mult_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to hold the value n-1 (used with n = WIDTH+1 for the iteration counter).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_add_datapath.sv
// Shift-and-add datapath: one adder, one right shift of the {acc_hi, mplier} pair per step.
module shift_add_datapath #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   load_a,
  input  logic [WIDTH-1:0]   load_b,
  output logic [2*WIDTH-1:0] result
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH:0]   sum;

  // Carry is kept so it can shift into the accumulator MSB.
  assign sum    = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : '0);
  assign result = {acc_hi, mplier};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand  <= '0;
      acc_hi <= '0;
      mplier <= '0;
    end else if (load) begin
      mcand  <= load_a;
      mplier <= load_b;
      acc_hi <= '0;
    end else if (step) begin
      acc_hi <= sum[WIDTH:1];
      mplier <= {sum[0], mplier[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/sequential_multiplier.sv
// Iterative unsigned WIDTH x WIDTH multiplier with start/done handshake.
// Optional zero-operand shortcut: define SEQ_MULT_ZERO_SKIP_EN.
module sequential_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               done,
  output logic               busy,
  output logic [STATE_W-1:0] state_dbg
);

  // Handshake: start is sampled only in IDLE; the accepting edge captures the operands.
  // done is a one-cycle pulse with product valid in that cycle; product holds until the next done.
  localparam int CW = clog2(WIDTH + 1);

  state_t             state;
  logic [CW-1:0]      count;
  logic               load;
  logic               step;
  logic               zero_op;
  logic [WIDTH-1:0]   load_b;
  logic [2*WIDTH-1:0] dp_result;

`ifdef SEQ_MULT_ZERO_SKIP_EN
  // Loading a zero multiplier makes the datapath result 0 without iterating.
  assign zero_op = (multiplicand == '0) || (multiplier == '0);
  assign load_b  = zero_op ? '0 : multiplier;
`else
  assign zero_op = 1'b0;
  assign load_b  = multiplier;
`endif

  assign load      = (state == IDLE) && start;
  assign step      = (state == CALC);
  assign state_dbg = state;

  shift_add_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .load_a (multiplicand),
    .load_b (load_b),
    .result (dp_result)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      product <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy  <= 1'b1;
            count <= '0;
            state <= zero_op ? DONE : CALC;
          end
        end
        CALC: begin
          done  <= 1'b0;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          product <= dp_result;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_multiplier.sv
// Self-checking bench for sequential_multiplier at WIDTH=8 and WIDTH=16.
module tb_sequential_multiplier;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] p8;
  logic        done8, busy8;
  logic [1:0]  st8;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] p16;
  logic        done16, busy16;
  logic [1:0]  st16;

  int n_checks = 0;
  int n_pass = 0;
  int edge_cnt = 0;
  int last_done_edge = 0;
  bit prev_done8 = 1'b0;
  bit prev_done16 = 1'b0;

  logic [31:0] exp_q8[$];
  logic [31:0] exp_q16[$];

  sequential_multiplier #(.WIDTH(8)) dut8 (
    .clk          (clk),
    .reset        (reset),
    .start        (start8),
    .multiplicand (a8),
    .multiplier   (b8),
    .product      (p8),
    .done         (done8),
    .busy         (busy8),
    .state_dbg    (st8)
  );

  sequential_multiplier #(.WIDTH(16)) dut16 (
    .clk          (clk),
    .reset        (reset),
    .start        (start16),
    .multiplicand (a16),
    .multiplier   (b16),
    .product      (p16),
    .done         (done16),
    .busy         (busy16),
    .state_dbg    (st16)
  );

  // Clock / edge counter
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int exp_lat(input logic [15:0] a, input logic [15:0] b, input int w);
`ifdef SEQ_MULT_ZERO_SKIP_EN
    // accept edge followed directly by the DONE edge
    if (a == '0 || b == '0) return 1;
`endif
    return w + 1;
  endfunction

  // Scoreboard: expected products popped on each done pulse
  always @(negedge clk) begin
    if (done8) begin
      if (exp_q8.size() == 0) check("done8_spurious", 32'(done8), 32'd0);
      else begin
        check("product8", 32'(p8), exp_q8.pop_front());
        check("busy8_at_done", 32'(busy8), 32'd0);
      end
    end
    if (prev_done8) check("done8_one_cycle", 32'(done8), 32'd0);
    prev_done8 = done8;
    if (done16) begin
      if (exp_q16.size() == 0) check("done16_spurious", 32'(done16), 32'd0);
      else begin
        check("product16", p16, exp_q16.pop_front());
        check("busy16_at_done", 32'(busy16), 32'd0);
      end
    end
    if (prev_done16) check("done16_one_cycle", 32'(done16), 32'd0);
    prev_done16 = done16;
  end

  // Driver: called at a negedge; returns at the negedge where done is seen.
  task automatic job(input bit w16, input logic [15:0] a, input logic [15:0] b,
                     input int lat, input bit hold, output bit saw_calc);
    int t0;
    bit seen;
    logic d, bz;
    logic [1:0] st;
    seen = 1'b0;
    saw_calc = 1'b0;
    d = 1'b0;
    if (w16) begin
      start16 = 1'b1; a16 = a; b16 = b;
      exp_q16.push_back(32'(a) * 32'(b));
    end else begin
      start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0];
      exp_q8.push_back(32'(a[7:0]) * 32'(b[7:0]));
    end
    t0 = edge_cnt + 1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      d  = w16 ? done16 : done8;
      bz = w16 ? busy16 : busy8;
      st = w16 ? st16 : st8;
      if (i == 0) begin
        check("busy_after_accept", 32'(bz), 32'd1);
        if (hold) begin
          a8 = 8'd9; b8 = 8'd9; a16 = 16'd9; b16 = 16'd9;
        end else begin
          start8 = 1'b0; start16 = 1'b0;
        end
      end
      if (st == 2'd1) saw_calc = 1'b1;
      if (d) seen = 1'b1;
    end
    if (seen) begin
      check("latency", 32'(edge_cnt - t0), 32'(lat));
      last_done_edge = edge_cnt;
    end else begin
      check("done_timeout", 32'(d), 32'd1);
    end
  endtask

  initial begin
    bit sc;
    int first_done;
    logic [15:0] ra, rb;

    // Reset state
    #2;
    check("rst_product8", 32'(p8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_state8", 32'(st8), 32'd0);
    check("rst_product16", p16, 32'd0);
    check("rst_busy16", 32'(busy16), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Directed products
    job(1'b0, 16'd13, 16'd11, 9, 1'b0, sc);
    job(1'b0, 16'd255, 16'd255, 9, 1'b0, sc);
    job(1'b0, 16'd1, 16'd255, 9, 1'b0, sc);
`ifdef SEQ_MULT_ZERO_SKIP_EN
    job(1'b0, 16'd0, 16'd200, 1, 1'b0, sc);
    check("zero_skip_no_calc", 32'(sc), 32'd0);
`else
    job(1'b0, 16'd0, 16'd200, 9, 1'b0, sc);
    check("zero_full_calc", 32'(sc), 32'd1);
`endif

    // Abort by reset mid-job: no done, outputs cleared
    start8 = 1'b1; a8 = 8'd100; b8 = 8'd3;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_product", 32'(p8), 32'd0);
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_state", 32'(st8), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_stays_idle", 32'(st8), 32'd0);
    job(1'b0, 16'd7, 16'd6, 9, 1'b0, sc);

    // Start held high, operands changed after accept; back-to-back jobs
    job(1'b0, 16'd20, 16'd5, 9, 1'b1, sc);
    first_done = last_done_edge;
    job(1'b0, 16'd9, 16'd9, 9, 1'b0, sc);
    check("b2b_period", 32'(last_done_edge - first_done), 32'd10);

    // Random vectors
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom_range(0, 255));
      rb = 16'($urandom_range(0, 255));
      job(1'b0, ra, rb, exp_lat(ra, rb, 8), 1'b0, sc);
    end
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      job(1'b1, ra, rb, exp_lat(ra, rb, 16), 1'b0, sc);
    end
    job(1'b1, 16'hFFFF, 16'hFFFF, 17, 1'b0, sc);

    repeat (3) @(negedge clk);
    check("sb8_drained", 32'(exp_q8.size()), 32'd0);
    check("sb16_drained", 32'(exp_q16.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
